grader_n: RTL and testbench
===========================

Name: grader_n

Overview:
- Parametrised successor to the fixed 4-slot grader. Scores a player Guess against the loaded masterPattern over NUM_SLOTS slots of SHAPE_W-bit shapes.
- Reports Znarly (right shape, right slot) and Zood (right shape, wrong slot) with Mastermind-style duplicate handling.
- Tracks the round count against the coin-purchased round budget and flags win or game-over.
- Sits between loadPattern/coinInput and the display/top-level FSM.

Parameters:
SHAPE_W, 3, bits per shape code
NUM_SLOTS, 4, pattern positions; pattern width P = NUM_SLOTS*SHAPE_W, slot i = bits [i*SHAPE_W +: SHAPE_W]
MAX_ROUNDS, 8, hard cap on rounds per game
CNT_W, $clog2(NUM_SLOTS+1), width of score outputs
RND_W, $clog2(MAX_ROUNDS+1), width of round values

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-low reset
StartGame  in  1  level; game starts/runs while high
ready  in  1  master pattern loaded (from loadPattern)
NumRounds  in  RND_W  rounds purchased, sampled at game start
masterPattern  in  P  secret pattern, latched at game start
Guess  in  P  player guess, latched when GradeIt is accepted
GradeIt  in  1  request to grade Guess
busy  out  1  high in EXACT/NEAR/DONE
GuessReady  out  1  one-cycle pulse; scores valid
Znarly  out  CNT_W  exact matches
Zood  out  CNT_W  shape-only matches
RoundNumber  out  RND_W  rounds graded this game
GameWon  out  1  Znarly==NUM_SLOTS on last grade
GameOver  out  1  game ended (win or budget exhausted)

Behaviour:
- Reset: async when reset==0. All outputs 0, state IDLE, internal latches cleared. This applies mid-grade too; no partial result is emitted.
- IDLE: when StartGame && ready && NumRounds!=0, go to PLAY.
  - Latch masterPattern.
  - Latch limit = min(NumRounds, MAX_ROUNDS).
  - Clear RoundNumber, GameWon, GameOver, Znarly, Zood.
  - NumRounds==0: stay IDLE. GradeIt is ignored in IDLE.
- PLAY: GradeIt==1 at an edge accepts a grade.
  - Latch Guess.
  - Clear the guess_used/master_used bit vectors and the score counters.
  - Go to EXACT.
- EXACT: NUM_SLOTS cycles, index i = 0..NUM_SLOTS-1. If G[i]==M[i]: Znarly++, set guess_used[i] and master_used[i].
- NEAR: NUM_SLOTS*NUM_SLOTS cycles, pairs (i,j) in row-major order, i = guess slot, j = master slot.
  - If !guess_used[i] && !master_used[j] && G[i]==M[j]: Zood++, set both used bits.
  - Each master slot is consumed at most once, and each guess slot matches at most once.
- DONE: one cycle.
  - GuessReady=1 and RoundNumber+1.
  - GameWon=(Znarly==NUM_SLOTS).
  - GameOver=GameWon || (RoundNumber+1==limit).
  - Next state is END if GameOver, else PLAY.
- Latency is fixed. GuessReady rises NUM_SLOTS + NUM_SLOTS² + 1 edges after the accepting edge (21 with defaults).
- Znarly/Zood hold their last value until the next accepted GradeIt.
- GradeIt while busy or in END is ignored and not queued. Guess changes after acceptance have no effect.
- END: flags and scores held. When StartGame==0, go to IDLE; GameWon/GameOver stay until the next game start.
- StartGame dropping in PLAY returns to IDLE. StartGame dropping while busy: the grade completes, then DONE, then IDLE.
- Counters saturate; Znarly+Zood ≤ NUM_SLOTS always.

Optional Feature:
- Macro GRADER_DUP_GUESS_EN.
- When defined:
  - Adds output port DupGuess (1 bit).
  - A graded Guess identical to the previous graded Guess of the same game still produces GuessReady with identical scores after the same latency.
  - DupGuess=1 for that cycle, and RoundNumber/GameOver are NOT advanced.
  - The first guess of a game is never a duplicate.
- When undefined: no DupGuess port; every grade consumes a round.

Test Plan:
- Exact win: defaults, master=12'h8D1, NumRounds=3, Guess=12'h8D1 -> GuessReady 21 edges after GradeIt, Znarly=4, Zood=0, RoundNumber=1, GameWon=1, GameOver=1.
- Swap: master=12'h8D1, Guess=12'h8CA -> Znarly=2, Zood=2, GameWon=0, RoundNumber increments.
- Duplicates: master=12'h8D1, Guess=12'h249 -> Znarly=1, Zood=0. Guess=12'h048 -> Znarly=0, Zood=1.
- Budget: NumRounds=2, two non-winning guesses -> GameOver=1 after second GuessReady, RoundNumber=2. A third GradeIt produces no GuessReady.
- Ignore/busy: GradeIt held high for 30 cycles -> exactly one accepted grade per EXACT/NEAR/DONE pass, and busy=1 throughout. GradeIt in IDLE -> no response.
- Reset mid-NEAR: drive reset=0 at cycle 10 of a grade -> all outputs 0 immediately, no GuessReady, IDLE after release. With GRADER_DUP_GUESS_EN, repeating 12'h8CA gives DupGuess=1 with RoundNumber unchanged.

Source files
------------

// File: rtl/grader_n.sv
// grader_n: parametrised Mastermind-style grader.
// It scores a latched Guess against a latched master pattern over NUM_SLOTS
// slots. The exact pass visits one slot per cycle. The near pass visits one
// (guess, master) pair per cycle. The grader also tracks rounds against the
// purchased budget.
// Optional macro GRADER_DUP_GUESS_EN adds the DupGuess output. With it, a
// repeat of the previous graded guess is scored but does not use up a round.
module grader_n #(
   parameter int SHAPE_W    = 3,
   parameter int NUM_SLOTS  = 4,
   parameter int MAX_ROUNDS = 8,
   parameter int CNT_W      = $clog2(NUM_SLOTS + 1),
   parameter int RND_W      = $clog2(MAX_ROUNDS + 1)
) (
   input  logic                         CLOCK_50,
   input  logic                         reset,
   input  logic                         StartGame,
   input  logic                         ready,
   input  logic [RND_W-1:0]             NumRounds,
   input  logic [NUM_SLOTS*SHAPE_W-1:0] masterPattern,
   input  logic [NUM_SLOTS*SHAPE_W-1:0] Guess,
   input  logic                         GradeIt,
   output logic                         busy,
   output logic                         GuessReady,
   output logic [CNT_W-1:0]             Znarly,
   output logic [CNT_W-1:0]             Zood,
   output logic [RND_W-1:0]             RoundNumber,
   output logic                         GameWon,
   output logic                         GameOver
`ifdef GRADER_DUP_GUESS_EN
   ,
   output logic                         DupGuess
`endif
);

   localparam int               P        = NUM_SLOTS * SHAPE_W;
   localparam int               IDX_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);
   localparam logic [RND_W-1:0] MAX_RND  = RND_W'(MAX_ROUNDS);

   typedef enum logic [2:0] {
      S_IDLE, S_PLAY, S_EXACT, S_NEAR, S_DONE, S_END
   } state_t;

   state_t               r_state;
   logic [P-1:0]         r_master;
   logic [P-1:0]         r_guess;
   logic [NUM_SLOTS-1:0] r_guess_used;
   logic [NUM_SLOTS-1:0] r_master_used;
   logic [IDX_W-1:0]     r_idx_i;
   logic [IDX_W-1:0]     r_idx_j;
   logic [CNT_W-1:0]     r_zn_cnt;
   logic [CNT_W-1:0]     r_zo_cnt;
   logic [RND_W-1:0]     r_limit;
   logic [RND_W-1:0]     r_round;
   logic [CNT_W-1:0]     r_znarly;
   logic [CNT_W-1:0]     r_zood;
   logic                 r_busy;
   logic                 r_guess_ready;
   logic                 r_game_won;
   logic                 r_game_over;
`ifdef GRADER_DUP_GUESS_EN
   logic [P-1:0]         r_prev_guess;
   logic                 r_have_prev;
   logic                 r_dup;
   logic                 w_dup;
`endif

   logic [SHAPE_W-1:0]   w_g_slot [NUM_SLOTS];
   logic [SHAPE_W-1:0]   w_m_slot [NUM_SLOTS];
   logic                 w_exact_hit;
   logic                 w_near_hit;
   logic [RND_W-1:0]     w_limit;
   logic [RND_W-1:0]     w_round_inc;
   logic [RND_W-1:0]     w_round_next;
   logic                 w_win;
   logic                 w_over_next;

   // Split the latched patterns into per-slot shape codes.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
         assign w_g_slot[gi] = r_guess[gi*SHAPE_W +: SHAPE_W];
         assign w_m_slot[gi] = r_master[gi*SHAPE_W +: SHAPE_W];
      end
   endgenerate

   assign w_exact_hit = (w_g_slot[r_idx_i] == w_m_slot[r_idx_i]);
   assign w_near_hit  = !r_guess_used[r_idx_i] && !r_master_used[r_idx_j] &&
                        (w_g_slot[r_idx_i] == w_m_slot[r_idx_j]);
   assign w_limit     = (NumRounds > MAX_RND) ? MAX_RND : NumRounds;
   assign w_round_inc = (r_round == MAX_RND) ? r_round : r_round + RND_W'(1);
   assign w_win       = (r_zn_cnt == FULL_CNT);

`ifdef GRADER_DUP_GUESS_EN
   // A repeated guess is scored normally but leaves the round budget untouched.
   assign w_dup        = r_have_prev && (r_guess == r_prev_guess);
   assign w_round_next = w_dup ? r_round : w_round_inc;
   assign w_over_next  = w_dup ? r_game_over : (w_win || (w_round_inc == r_limit));
   assign DupGuess     = r_dup;
`else
   assign w_round_next = w_round_inc;
   assign w_over_next  = w_win || (w_round_inc == r_limit);
`endif

   assign busy        = r_busy;
   assign GuessReady  = r_guess_ready;
   assign Znarly      = r_znarly;
   assign Zood        = r_zood;
   assign RoundNumber = r_round;
   assign GameWon     = r_game_won;
   assign GameOver    = r_game_over;

   // Game/grade sequencer with all outputs registered.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_master      <= '0;
         r_guess       <= '0;
         r_guess_used  <= '0;
         r_master_used <= '0;
         r_idx_i       <= '0;
         r_idx_j       <= '0;
         r_zn_cnt      <= '0;
         r_zo_cnt      <= '0;
         r_limit       <= '0;
         r_round       <= '0;
         r_znarly      <= '0;
         r_zood        <= '0;
         r_busy        <= 1'b0;
         r_guess_ready <= 1'b0;
         r_game_won    <= 1'b0;
         r_game_over   <= 1'b0;
`ifdef GRADER_DUP_GUESS_EN
         r_prev_guess  <= '0;
         r_have_prev   <= 1'b0;
         r_dup         <= 1'b0;
`endif
      end else begin
         r_guess_ready <= 1'b0;
`ifdef GRADER_DUP_GUESS_EN
         r_dup         <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (StartGame && ready && (NumRounds != '0)) begin
                  r_master    <= masterPattern;
                  r_limit     <= w_limit;
                  r_round     <= '0;
                  r_game_won  <= 1'b0;
                  r_game_over <= 1'b0;
                  r_znarly    <= '0;
                  r_zood      <= '0;
`ifdef GRADER_DUP_GUESS_EN
                  r_have_prev <= 1'b0;
`endif
                  r_state     <= S_PLAY;
               end
            end
            S_PLAY: begin
               if (!StartGame) begin
                  r_state <= S_IDLE;
               end else if (GradeIt) begin
                  r_guess       <= Guess;
                  r_guess_used  <= '0;
                  r_master_used <= '0;
                  r_zn_cnt      <= '0;
                  r_zo_cnt      <= '0;
                  r_idx_i       <= '0;
                  r_idx_j       <= '0;
                  r_busy        <= 1'b1;
                  r_state       <= S_EXACT;
               end
            end
            S_EXACT: begin
               if (w_exact_hit) begin
                  if (r_zn_cnt != FULL_CNT) r_zn_cnt <= r_zn_cnt + CNT_W'(1);
                  r_guess_used[r_idx_i]  <= 1'b1;
                  r_master_used[r_idx_i] <= 1'b1;
               end
               if (r_idx_i == LAST_IDX) begin
                  r_idx_i <= '0;
                  r_idx_j <= '0;
                  r_state <= S_NEAR;
               end else begin
                  r_idx_i <= r_idx_i + IDX_W'(1);
               end
            end
            S_NEAR: begin
               if (w_near_hit) begin
                  if (r_zo_cnt != FULL_CNT) r_zo_cnt <= r_zo_cnt + CNT_W'(1);
                  r_guess_used[r_idx_i]  <= 1'b1;
                  r_master_used[r_idx_j] <= 1'b1;
               end
               if (r_idx_j == LAST_IDX) begin
                  r_idx_j <= '0;
                  if (r_idx_i == LAST_IDX) begin
                     r_idx_i <= '0;
                     r_state <= S_DONE;
                  end else begin
                     r_idx_i <= r_idx_i + IDX_W'(1);
                  end
               end else begin
                  r_idx_j <= r_idx_j + IDX_W'(1);
               end
            end
            S_DONE: begin
               r_guess_ready <= 1'b1;
               r_busy        <= 1'b0;
               r_znarly      <= r_zn_cnt;
               r_zood        <= r_zo_cnt;
               r_game_won    <= w_win;
               r_round       <= w_round_next;
               r_game_over   <= w_over_next;
`ifdef GRADER_DUP_GUESS_EN
               r_dup         <= w_dup;
               r_prev_guess  <= r_guess;
               r_have_prev   <= 1'b1;
`endif
               if (!StartGame)       r_state <= S_IDLE;
               else if (w_over_next) r_state <= S_END;
               else                  r_state <= S_PLAY;
            end
            S_END: begin
               if (!StartGame) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_grader_n.sv
// tb_grader_n: randomized and directed bench for grader_n. The reference model
// is transaction-level. A grade is "in flight" for a fixed number of edges.
// The result comes from colour-count arithmetic rather than a slot scan.
module tb_grader_n;

   localparam int SHAPE_W    = 3;
   localparam int NUM_SLOTS  = 4;
   localparam int MAX_ROUNDS = 8;
   localparam int CNT_W      = $clog2(NUM_SLOTS + 1);
   localparam int RND_W      = $clog2(MAX_ROUNDS + 1);
   localparam int P          = NUM_SLOTS * SHAPE_W;
   localparam int LAT        = NUM_SLOTS + NUM_SLOTS * NUM_SLOTS + 1;
`ifdef GRADER_DUP_GUESS_EN
   localparam bit DUP_EN = 1'b1;
`else
   localparam bit DUP_EN = 1'b0;
`endif
   localparam int PH_IDLE = 0, PH_PLAY = 1, PH_END = 2;

   logic             CLOCK_50 = 1'b0;
   logic             reset;
   logic             StartGame, ready, GradeIt;
   logic [RND_W-1:0] NumRounds;
   logic [P-1:0]     masterPattern, Guess;
   logic             busy, GuessReady, GameWon, GameOver;
   logic [CNT_W-1:0] Znarly, Zood;
   logic [RND_W-1:0] RoundNumber;
`ifdef GRADER_DUP_GUESS_EN
   logic             DupGuess;
`endif

   int total = 0;
   int bad   = 0;

   grader_n #(
      .SHAPE_W(SHAPE_W), .NUM_SLOTS(NUM_SLOTS), .MAX_ROUNDS(MAX_ROUNDS),
      .CNT_W(CNT_W), .RND_W(RND_W)
   ) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .StartGame(StartGame), .ready(ready),
      .NumRounds(NumRounds), .masterPattern(masterPattern), .Guess(Guess),
      .GradeIt(GradeIt), .busy(busy), .GuessReady(GuessReady), .Znarly(Znarly),
      .Zood(Zood), .RoundNumber(RoundNumber), .GameWon(GameWon), .GameOver(GameOver)
`ifdef GRADER_DUP_GUESS_EN
      , .DupGuess(DupGuess)
`endif
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // ---------------- reference model ----------------
   int               m_phase = PH_IDLE;
   int               m_flight = 0;
   logic [P-1:0]     m_master = '0, m_guess = '0, m_prev = '0;
   logic             m_have_prev = 1'b0;
   logic [RND_W-1:0] m_limit = '0, m_round = '0;
   logic [CNT_W-1:0] m_zn = '0, m_zo = '0;
   logic             m_won = 1'b0, m_over = 1'b0, m_pulse = 1'b0, m_dup = 1'b0;

   // Mastermind score: exact hits, then total colour overlap minus exact hits.
   function automatic void score(input logic [P-1:0] g, input logic [P-1:0] m,
                                 output int ex, output int nr);
      int cg [1 << SHAPE_W];
      int cm [1 << SHAPE_W];
      int tot;
      for (int s = 0; s < (1 << SHAPE_W); s++) begin
         cg[s] = 0;
         cm[s] = 0;
      end
      ex = 0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (g[i*SHAPE_W +: SHAPE_W] == m[i*SHAPE_W +: SHAPE_W]) ex++;
         cg[g[i*SHAPE_W +: SHAPE_W]]++;
         cm[m[i*SHAPE_W +: SHAPE_W]]++;
      end
      tot = 0;
      for (int s = 0; s < (1 << SHAPE_W); s++) tot += (cg[s] < cm[s]) ? cg[s] : cm[s];
      nr = tot - ex;
   endfunction

   initial begin
      int ex, nr;
      logic dup;
      forever begin
         @(posedge CLOCK_50 or negedge reset);
         if (!reset) begin
            m_phase = PH_IDLE; m_flight = 0; m_master = '0; m_guess = '0;
            m_prev = '0; m_have_prev = 1'b0; m_limit = '0; m_round = '0;
            m_zn = '0; m_zo = '0; m_won = 1'b0; m_over = 1'b0;
            m_pulse = 1'b0; m_dup = 1'b0;
         end else begin
            m_pulse = 1'b0;
            m_dup   = 1'b0;
            if (m_flight != 0) begin
               m_flight--;
               if (m_flight == 0) begin
                  score(m_guess, m_master, ex, nr);
                  m_zn    = CNT_W'(ex);
                  m_zo    = CNT_W'(nr);
                  m_pulse = 1'b1;
                  m_won   = (ex == NUM_SLOTS);
                  dup     = DUP_EN && m_have_prev && (m_guess == m_prev);
                  m_dup   = dup;
                  if (!dup) begin
                     m_round = m_round + RND_W'(1);
                     m_over  = m_won || (m_round == m_limit);
                  end
                  m_prev = m_guess;
                  m_have_prev = 1'b1;
                  if (!StartGame)  m_phase = PH_IDLE;
                  else if (m_over) m_phase = PH_END;
                  else             m_phase = PH_PLAY;
               end
            end else if (m_phase == PH_IDLE) begin
               if (StartGame && ready && NumRounds != '0) begin
                  m_phase = PH_PLAY;
                  m_master = masterPattern;
                  m_limit = (int'(NumRounds) > MAX_ROUNDS) ? RND_W'(MAX_ROUNDS) : NumRounds;
                  m_round = '0; m_won = 1'b0; m_over = 1'b0;
                  m_zn = '0; m_zo = '0; m_have_prev = 1'b0;
               end
            end else if (m_phase == PH_PLAY) begin
               if (!StartGame) m_phase = PH_IDLE;
               else if (GradeIt) begin
                  m_guess  = Guess;
                  m_flight = LAT;
               end
            end else begin
               if (!StartGame) m_phase = PH_IDLE;
            end
         end
      end
   end

   // ---------------- per-cycle comparison ----------------
   initial begin
      logic exp_busy;
      forever begin
         @(negedge CLOCK_50);
         exp_busy = (m_flight != 0);
         total++;
         if (busy !== exp_busy || GuessReady !== m_pulse || Znarly !== m_zn ||
             Zood !== m_zo || RoundNumber !== m_round || GameWon !== m_won ||
             GameOver !== m_over
`ifdef GRADER_DUP_GUESS_EN
             || DupGuess !== m_dup
`endif
            ) begin
            bad++;
            $display("FAIL cycle t=%0t got busy=%0b rdy=%0b zn=%0d zo=%0d rnd=%0d won=%0b over=%0b expected busy=%0b rdy=%0b zn=%0d zo=%0d rnd=%0d won=%0b over=%0b",
                     $time, busy, GuessReady, Znarly, Zood, RoundNumber, GameWon, GameOver,
                     exp_busy, m_pulse, m_zn, m_zo, m_round, m_won, m_over);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string nm, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end else begin
         $display("check %s: %0d ok", nm, act);
      end
   endtask

   function automatic logic [P-1:0] rand_pat();
      logic [P-1:0] p;
      p = P'($urandom);
      if ($urandom_range(0, 1) == 0)
         for (int i = 0; i < NUM_SLOTS; i++) p[i*SHAPE_W +: SHAPE_W] = SHAPE_W'($urandom_range(0, 3));
      return p;
   endfunction

   task automatic start_game(input logic [P-1:0] m, input int nr);
      masterPattern = m;
      NumRounds = RND_W'(nr);
      ready = 1'b1;
      StartGame = 1'b1;
      @(negedge CLOCK_50);
   endtask

   task automatic end_game();
      StartGame = 1'b0;
      repeat (3) @(negedge CLOCK_50);
   endtask

   // Issues one GradeIt at the current negedge and waits a bounded time for the result.
   task automatic grade(input string nm, input logic [P-1:0] g, input int ezn, input int ezo,
                        input int ernd, input int ewon, input int eover, input int edup,
                        input bit expect_resp);
      int lat;
      lat = 0;
      Guess = g;
      GradeIt = 1'b1;
      @(negedge CLOCK_50);
      GradeIt = 1'b0;
      Guess = P'($urandom);
      for (int k = 1; k <= 30; k++) begin
         @(negedge CLOCK_50);
         if (GuessReady === 1'b1 && lat == 0) lat = k;
      end
      if (expect_resp) begin
         check({nm, "_latency"}, lat, LAT);
         check({nm, "_znarly"}, int'(Znarly), ezn);
         check({nm, "_zood"}, int'(Zood), ezo);
         check({nm, "_round"}, int'(RoundNumber), ernd);
         check({nm, "_won"}, int'(GameWon), ewon);
         check({nm, "_over"}, int'(GameOver), eover);
`ifdef GRADER_DUP_GUESS_EN
         total++;
         if (lat != 0 && int'(m_dup) == 0 && edup != 0) begin
            bad++;
            $display("FAIL %s_dupmodel: got 0 expected %0d", nm, edup);
         end
`endif
      end else begin
         check({nm, "_noresp"}, lat, 0);
      end
      if (edup < 0) $display("unused");
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int ex, nr, cnt_rdy, cnt_busy;
      reset = 1'b1; StartGame = 1'b0; ready = 1'b0; GradeIt = 1'b0;
      NumRounds = '0; masterPattern = '0; Guess = '0;
      #2 reset = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      check("rst_busy", int'(busy), 0);
      check("rst_ready", int'(GuessReady), 0);
      check("rst_round", int'(RoundNumber), 0);
      check("rst_over", int'(GameOver), 0);
      reset = 1'b1;
      @(negedge CLOCK_50);

      // Pin the reference scorer to hand-computed values.
      score(12'h8D1, 12'h8D1, ex, nr); check("model_win", ex * 10 + nr, 40);
      score(12'h8CA, 12'h8D1, ex, nr); check("model_swap", ex * 10 + nr, 22);
      score(12'h249, 12'h8D1, ex, nr); check("model_dup1", ex * 10 + nr, 10);
      score(12'h048, 12'h8D1, ex, nr); check("model_dup2", ex * 10 + nr, 1);

      // GradeIt while idle, including a start attempt with zero rounds.
      grade("idle", 12'h8D1, 0, 0, 0, 0, 0, 0, 1'b0);
      masterPattern = 12'h8D1; NumRounds = '0; ready = 1'b1; StartGame = 1'b1;
      @(negedge CLOCK_50);
      grade("zero_rounds", 12'h8D1, 0, 0, 0, 0, 0, 0, 1'b0);
      end_game();

      // Exact win on the first guess.
      start_game(12'h8D1, 3);
      grade("win", 12'h8D1, 4, 0, 1, 1, 1, 0, 1'b1);
      grade("after_win", 12'h8CA, 0, 0, 0, 0, 0, 0, 1'b0);
      end_game();
      check("won_held_idle", int'(GameWon), 1);

      // Swap, duplicate handling, repeated guess.
      start_game(12'h8D1, 5);
      check("start_clr_won", int'(GameWon), 0);
      check("start_clr_zn", int'(Znarly), 0);
      grade("swap", 12'h8CA, 2, 2, 1, 0, 0, 0, 1'b1);
      grade("repeat", 12'h8CA, 2, 2, DUP_EN ? 1 : 2, 0, 0, DUP_EN ? 1 : 0, 1'b1);
      grade("dups1", 12'h249, 1, 0, DUP_EN ? 2 : 3, 0, 0, 0, 1'b1);
      grade("dups2", 12'h048, 0, 1, DUP_EN ? 3 : 4, 0, 0, 0, 1'b1);
      end_game();

      // Budget exhaustion.
      start_game(12'h8D1, 2);
      grade("bud1", 12'h249, 1, 0, 1, 0, 0, 0, 1'b1);
      grade("bud2", 12'h048, 0, 1, 2, 0, 1, 0, 1'b1);
      grade("bud3", 12'h8CA, 0, 1, 2, 0, 1, 0, 1'b0);
      end_game();

      // GradeIt held high for 30 cycles.
      start_game(12'h8D1, 8);
      Guess = 12'h8CA;
      GradeIt = 1'b1;
      cnt_rdy = 0; cnt_busy = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge CLOCK_50);
         if (GuessReady === 1'b1) cnt_rdy++;
         if (busy === 1'b1) cnt_busy++;
      end
      GradeIt = 1'b0;
      check("hold_ready_count", cnt_rdy, 1);
      check("hold_busy_count", cnt_busy, 29);
      repeat (25) @(negedge CLOCK_50);
      end_game();

      // Reset in the middle of the near pass.
      start_game(12'h8D1, 5);
      grade("pre_rst", 12'h8CA, 2, 2, 1, 0, 0, 0, 1'b1);
      Guess = 12'h249;
      GradeIt = 1'b1;
      @(negedge CLOCK_50);
      GradeIt = 1'b0;
      repeat (9) @(negedge CLOCK_50);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_zn", int'(Znarly), 0);
      check("mid_rst_zo", int'(Zood), 0);
      check("mid_rst_round", int'(RoundNumber), 0);
      StartGame = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      reset = 1'b1;
      cnt_rdy = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge CLOCK_50);
         if (GuessReady === 1'b1) cnt_rdy++;
      end
      check("post_rst_noresp", cnt_rdy, 0);

      // Randomized play checked cycle by cycle against the model.
      StartGame = 1'b1; ready = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         @(negedge CLOCK_50);
         if ($urandom_range(0, 59) == 0) StartGame = !StartGame;
         ready = ($urandom_range(0, 7) != 0);
         NumRounds = RND_W'($urandom_range(0, 15));
         masterPattern = rand_pat();
         GradeIt = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) != 0) Guess = rand_pat();
      end
      GradeIt = 1'b0;
      StartGame = 1'b0;
      repeat (30) @(negedge CLOCK_50);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
